maze_mem_arbiter: RTL and testbench

//  Shares the single-port maze cell RAM (2-bit cells: 00 out, 01 frontier, 10 wall, 11 path) between three requesters:
//  0 = carver, 1 = solver, 2 = display scanner. Round-robin arbitration, with a bounded lock for carver read-modify-write.

---
 rtl/maze_mem_arbiter_if.sv | 17 +
 rtl/maze_mem_arbiter.sv | 119 +++++++++++
 tb/tb_maze_mem_arbiter.sv | 261 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/maze_mem_arbiter_if.sv
// Requester-side bus of the maze cell RAM arbiter: three packed request lanes plus shared read return.
interface maze_mem_arbiter_if #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 2
);
  logic [2:0]          req;
  logic [2:0]          we;
  logic [2:0]          lock;
  logic [3*ADDR_W-1:0] addr;
  logic [3*DATA_W-1:0] wdata;
  logic [2:0]          gnt;
  logic [2:0]          rvalid;
  logic [DATA_W-1:0]   rdata;

  modport master (output req, we, lock, addr, wdata, input gnt, rvalid, rdata);
  modport slave  (input req, we, lock, addr, wdata, output gnt, rvalid, rdata);
endinterface

// File: rtl/maze_mem_arbiter.sv
// Round-robin arbiter for the single-port maze cell RAM (carver/solver/display) with bounded carver lock.
// Optional MAZE_ARB_DISPLAY_PRIO_EN: display wins whenever no lock owner is active.
module maze_mem_arbiter #(
  parameter int ADDR_W   = 12,
  parameter int DATA_W   = 2,
  parameter int LOCK_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  maze_mem_arbiter_if.slave bus,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);
  localparam int CW = $clog2(LOCK_MAX + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(LOCK_MAX - 1);

  logic [1:0]    rr_ptr, owner, win, c1, c2, rv_idx;
  logic          owner_vld, owned, win_vld, acq, rr_upd, rv_vld;
  logic [CW-1:0] lock_cnt;
  logic [2:0]    ban;

  function automatic logic [1:0] inc3(input logic [1:0] x);
    return (x == 2'd2) ? 2'd0 : x + 2'd1;
  endfunction

  always_comb begin
    c1      = inc3(rr_ptr);
    c2      = inc3(c1);
    owned   = owner_vld && bus.lock[owner];
    win_vld = 1'b0;
    win     = rr_ptr;
    // Grants are forced low while reset is held, even though they are combinational.
    if (!rst) begin
      if (owned) begin
        win_vld = bus.req[owner];
        win     = owner;
      end
`ifdef MAZE_ARB_DISPLAY_PRIO_EN
      else if (bus.req[2]) begin
        win_vld = 1'b1;
        win     = 2'd2;
      end
`endif
      else if (bus.req[rr_ptr]) begin
        win_vld = 1'b1;
        win     = rr_ptr;
      end else if (bus.req[c1]) begin
        win_vld = 1'b1;
        win     = c1;
      end else if (bus.req[c2]) begin
        win_vld = 1'b1;
        win     = c2;
      end
    end
    acq = !owned && win_vld && bus.lock[win] && !ban[win];
`ifdef MAZE_ARB_DISPLAY_PRIO_EN
    rr_upd = win_vld && (win != 2'd2);
`else
    rr_upd = win_vld;
`endif
  end

  always_comb begin
    bus.gnt   = '0;
    mem_en    = win_vld;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    for (int i = 0; i < 3; i++) begin
      if (win_vld && win == 2'(i)) begin
        bus.gnt[i] = 1'b1;
        mem_we     = bus.we[i];
        mem_addr   = bus.addr[i*ADDR_W +: ADDR_W];
        mem_wdata  = bus.wdata[i*DATA_W +: DATA_W];
      end
    end
  end

  assign bus.rvalid = rv_vld ? (3'b001 << rv_idx) : 3'b000;
  assign bus.rdata  = mem_rdata;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr    <= 2'd0;
      owner_vld <= 1'b0;
      owner     <= 2'd0;
      lock_cnt  <= '0;
      ban       <= 3'b000;
      rv_vld    <= 1'b0;
      rv_idx    <= 2'd0;
    end else begin
      if (rr_upd) rr_ptr <= inc3(win);
      rv_vld <= win_vld && !mem_we;
      rv_idx <= win;
      for (int i = 0; i < 3; i++)
        if (!bus.lock[i]) ban[i] <= 1'b0;
      // lock_cnt counts held cycles including the acquire cycle; release when it reaches LOCK_MAX.
      if (owned) begin
        if (lock_cnt == CNT_LAST) begin
          owner_vld  <= 1'b0;
          lock_cnt   <= '0;
          ban[owner] <= 1'b1;
        end else begin
          lock_cnt <= lock_cnt + CW'(1);
        end
      end else if (acq) begin
        owner_vld <= 1'b1;
        owner     <= win;
        lock_cnt  <= CW'(1);
      end else begin
        owner_vld <= 1'b0;
        lock_cnt  <= '0;
      end
    end
  end
endmodule

// File: tb/tb_maze_mem_arbiter.sv
// Randomized and directed bench for maze_mem_arbiter against a cycle-level behavioural model.
module tb_maze_mem_arbiter;
  localparam int ADDR_W = 12, DATA_W = 2, LOCK_MAX = 4;
`ifdef MAZE_ARB_DISPLAY_PRIO_EN
  localparam bit PRIO = 1'b1;
`else
  localparam bit PRIO = 1'b0;
`endif

  logic clk = 1'b0, rst = 1'b1;
  logic mem_en, mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata, mem_rdata;
  logic [DATA_W-1:0] ram [4096];
  int checks = 0, failures = 0;

  maze_mem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus();
  maze_mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .LOCK_MAX(LOCK_MAX)) dut (
    .clk(clk), .rst(rst), .bus(bus), .mem_en(mem_en), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata));

  always #5 clk = ~clk;

  // RAM with 1-cycle read latency; contents reload while reset is sampled high.
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 4096; i++) ram[i] <= 2'(i * 7);
    end else if (mem_en) begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      else mem_rdata <= ram[mem_addr];
    end
  end

  // Behavioural model state
  int m_rr, m_owner, m_held, m_rv;
  bit [2:0] m_ban;
  logic [1:0] m_rv_data;
  logic [1:0] shadow [4096];

  function automatic void model_reset();
    m_rr = 0; m_owner = -1; m_held = 0; m_rv = -1; m_ban = 3'b000; m_rv_data = 2'b00;
    for (int i = 0; i < 4096; i++) shadow[i] = 2'(i * 7);
  endfunction

  function automatic int model_win();
    if (m_owner >= 0 && bus.lock[m_owner]) return bus.req[m_owner] ? m_owner : -1;
    if (PRIO && bus.req[2]) return 2;
    for (int k = 0; k < 3; k++) if (bus.req[(m_rr + k) % 3]) return (m_rr + k) % 3;
    return -1;
  endfunction

  function automatic void model_step(int w);
    bit owned;
    bit [2:0] ban_old;
    int a;
    owned = (m_owner >= 0) && bus.lock[m_owner];
    ban_old = m_ban;
    if (w >= 0 && !(PRIO && w == 2)) m_rr = (w + 1) % 3;
    m_rv = -1;
    if (w >= 0) begin
      a = int'(bus.addr[w*ADDR_W +: ADDR_W]);
      if (bus.we[w]) shadow[a] = bus.wdata[w*DATA_W +: DATA_W];
      else begin m_rv = w; m_rv_data = shadow[a]; end
    end
    for (int i = 0; i < 3; i++) if (!bus.lock[i]) m_ban[i] = 1'b0;
    if (owned) begin
      m_held++;
      if (m_held == LOCK_MAX) begin m_ban[m_owner] = 1'b1; m_owner = -1; m_held = 0; end
    end else if (w >= 0 && bus.lock[w] && !ban_old[w]) begin
      m_owner = w; m_held = 1;
    end else begin
      m_owner = -1; m_held = 0;
    end
  endfunction

  task automatic tick();
    model_step(model_win());
    @(posedge clk); #1;
  endtask

  task automatic set_req(int i, bit r, bit w, bit l, logic [ADDR_W-1:0] a, logic [DATA_W-1:0] d);
    bus.req[i] = r; bus.we[i] = w; bus.lock[i] = l;
    bus.addr[i*ADDR_W +: ADDR_W] = a;
    bus.wdata[i*DATA_W +: DATA_W] = d;
  endtask

  task automatic clear_all();
    bus.req = '0; bus.we = '0; bus.lock = '0; bus.addr = '0; bus.wdata = '0;
  endtask

  task automatic test_reset();
    bus.req = 3'b111; bus.we = 3'b000; bus.lock = 3'b111; bus.addr = '0; bus.wdata = '0;
    #3;
    checks++; if (bus.gnt !== 3'b000) begin failures++; $display("FAIL reset_gnt got=%b exp=000", bus.gnt); end
    checks++; if (mem_en !== 1'b0 || mem_we !== 1'b0) begin failures++; $display("FAIL reset_mem got=%b%b exp=00", mem_en, mem_we); end
    checks++; if (bus.rvalid !== 3'b000) begin failures++; $display("FAIL reset_rvalid got=%b exp=000", bus.rvalid); end
    clear_all();
    @(posedge clk); @(negedge clk); rst = 1'b0; model_reset();
    @(posedge clk); #1;
  endtask

  task automatic test_rotation();
    logic [2:0] rot [3];
    logic [2:0] eg, erv;
    rot[0] = 3'b001; rot[1] = 3'b010; rot[2] = 3'b100;
    set_req(0, 1, 0, 0, 12'h011, 2'b00);
    set_req(1, 1, 0, 0, 12'h022, 2'b00);
    set_req(2, 1, 0, 0, 12'h033, 2'b00);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      eg  = PRIO ? 3'b100 : rot[k];
      erv = (k == 0) ? 3'b000 : (PRIO ? 3'b100 : rot[k-1]);
      checks++; if (bus.gnt !== eg) begin failures++; $display("FAIL rot_gnt%0d got=%b exp=%b", k, bus.gnt, eg); end
      checks++; if (bus.rvalid !== erv) begin failures++; $display("FAIL rot_rvalid%0d got=%b exp=%b", k, bus.rvalid, erv); end
      tick();
    end
    clear_all();
    @(negedge clk);
    checks++; if (bus.rvalid !== 3'b100) begin failures++; $display("FAIL rot_rvalid_last got=%b exp=100", bus.rvalid); end
    checks++; if (bus.rdata !== m_rv_data) begin failures++; $display("FAIL rot_rdata got=%b exp=%b", bus.rdata, m_rv_data); end
    checks++; if (bus.gnt !== 3'b000 || mem_en !== 1'b0) begin failures++; $display("FAIL rot_idle got=%b/%b exp=000/0", bus.gnt, mem_en); end
    tick();
  endtask

  task automatic test_write();
    set_req(0, 1, 1, 0, 12'h041, 2'b11);
    @(negedge clk);
    checks++; if (bus.gnt !== 3'b001) begin failures++; $display("FAIL wr_gnt got=%b exp=001", bus.gnt); end
    checks++; if (mem_en !== 1'b1 || mem_we !== 1'b1) begin failures++; $display("FAIL wr_strobe got=%b%b exp=11", mem_en, mem_we); end
    checks++; if (mem_addr !== 12'h041 || mem_wdata !== 2'b11) begin failures++; $display("FAIL wr_bus got=%h/%b exp=041/11", mem_addr, mem_wdata); end
    tick();
    set_req(0, 1, 0, 0, 12'h041, 2'b00);
    @(negedge clk);
    checks++; if (bus.rvalid !== 3'b000) begin failures++; $display("FAIL wr_no_rvalid got=%b exp=000", bus.rvalid); end
    tick();
    clear_all();
    @(negedge clk);
    checks++; if (bus.rvalid !== 3'b001 || bus.rdata !== 2'b11) begin failures++; $display("FAIL wr_readback got=%b/%b exp=001/11", bus.rvalid, bus.rdata); end
    tick();
  endtask

  task automatic test_lock();
    set_req(0, 1, 0, 1, 12'h005, 2'b00);
    @(negedge clk);
    checks++; if (bus.gnt !== 3'b001) begin failures++; $display("FAIL lk_acquire got=%b exp=001", bus.gnt); end
    tick();
    set_req(1, 1, 0, 0, 12'h006, 2'b00);
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      checks++; if (bus.gnt !== 3'b001) begin failures++; $display("FAIL lk_owned%0d got=%b exp=001", k, bus.gnt); end
      tick();
    end
    set_req(0, 0, 0, 0, 12'h000, 2'b00);
    @(negedge clk);
    checks++; if (bus.gnt !== 3'b010) begin failures++; $display("FAIL lk_release got=%b exp=010", bus.gnt); end
    tick();
    clear_all();
  endtask

  task automatic test_forced_release();
    logic [2:0] exp_g [7];
    exp_g[0] = 3'b001; exp_g[1] = 3'b001; exp_g[2] = 3'b001; exp_g[3] = 3'b001;
    exp_g[4] = 3'b010; exp_g[5] = 3'b001; exp_g[6] = 3'b010;
    for (int k = 0; k < 7; k++) begin
      set_req(0, 1, 0, 1, 12'h100, 2'b00);
      set_req(1, (k != 5), 0, 0, 12'h101, 2'b00);
      @(negedge clk);
      checks++; if (bus.gnt !== exp_g[k]) begin failures++; $display("FAIL fr_cycle%0d got=%b exp=%b", k + 1, bus.gnt, exp_g[k]); end
      tick();
    end
    clear_all();
    tick();
    set_req(0, 1, 0, 1, 12'h100, 2'b00);
    set_req(1, 1, 0, 0, 12'h101, 2'b00);
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      checks++; if (bus.gnt !== 3'b001) begin failures++; $display("FAIL fr_relock%0d got=%b exp=001", k, bus.gnt); end
      tick();
    end
    clear_all();
    tick();
  endtask

  task automatic test_reset_mid();
    logic [2:0] eg;
    set_req(0, 1, 0, 1, 12'h200, 2'b00);
    @(negedge clk);
    checks++; if (bus.gnt !== 3'b001) begin failures++; $display("FAIL rm_gnt got=%b exp=001", bus.gnt); end
    tick();
    #1 rst = 1'b1;
    #1;
    checks++; if (bus.rvalid !== 3'b000) begin failures++; $display("FAIL rm_rvalid got=%b exp=000", bus.rvalid); end
    checks++; if (bus.gnt !== 3'b000 || mem_en !== 1'b0) begin failures++; $display("FAIL rm_gnt_rst got=%b/%b exp=000/0", bus.gnt, mem_en); end
    clear_all();
    model_reset();
    @(posedge clk); @(negedge clk);
    rst = 1'b0;
    set_req(0, 1, 0, 0, 12'h001, 2'b00);
    set_req(1, 1, 0, 0, 12'h002, 2'b00);
    set_req(2, 1, 0, 0, 12'h003, 2'b00);
    #1;
    eg = PRIO ? 3'b100 : 3'b001;
    checks++; if (bus.gnt !== eg) begin failures++; $display("FAIL rm_rrptr got=%b exp=%b", bus.gnt, eg); end
    checks++; if (bus.rvalid !== 3'b000) begin failures++; $display("FAIL rm_no_spurious got=%b exp=000", bus.rvalid); end
    tick();
    clear_all();
    tick();
  endtask

  task automatic test_random();
    int w;
    logic [2:0] eg, erv, granted;
    int nfail0;
    nfail0 = failures;
    clear_all();
    for (int cyc = 0; cyc < 500; cyc++) begin
      @(negedge clk);
      w = model_win();
      eg = (w >= 0) ? 3'(1 << w) : 3'b000;
      erv = (m_rv >= 0) ? 3'(1 << m_rv) : 3'b000;
      checks++; if (bus.gnt !== eg) begin failures++; $display("FAIL rnd_gnt c%0d got=%b exp=%b", cyc, bus.gnt, eg); end
      checks++; if (bus.rvalid !== erv) begin failures++; $display("FAIL rnd_rvalid c%0d got=%b exp=%b", cyc, bus.rvalid, erv); end
      if (m_rv >= 0) begin
        checks++; if (bus.rdata !== m_rv_data) begin failures++; $display("FAIL rnd_rdata c%0d got=%b exp=%b", cyc, bus.rdata, m_rv_data); end
      end
      if (w >= 0) begin
        checks++;
        if (mem_en !== 1'b1 || mem_we !== bus.we[w] || mem_addr !== bus.addr[w*ADDR_W +: ADDR_W]
            || (bus.we[w] && mem_wdata !== bus.wdata[w*DATA_W +: DATA_W])) begin
          failures++; $display("FAIL rnd_mem c%0d got=%b%b/%h/%b req=%0d", cyc, mem_en, mem_we, mem_addr, mem_wdata, w);
        end
      end else begin
        checks++; if (mem_en !== 1'b0 || mem_we !== 1'b0) begin failures++; $display("FAIL rnd_idle c%0d got=%b%b exp=00", cyc, mem_en, mem_we); end
      end
      if (failures - nfail0 > 20) break;
      granted = eg;
      tick();
      for (int i = 0; i < 3; i++) begin
        if (!bus.req[i] || granted[i])
          set_req(i, ($urandom_range(2, 0) != 0), $urandom_range(1, 0) == 1, bus.lock[i],
                  12'($urandom_range(31, 0)), 2'($urandom_range(3, 0)));
        if ($urandom_range(3, 0) == 0) bus.lock[i] = ~bus.lock[i];
      end
    end
    clear_all();
    tick();
  endtask

  initial begin
    model_reset();
    test_reset();
    test_rotation();
    test_write();
    test_lock();
    test_forced_release();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
